// File: rtl/nzcv_flag_stack_if.sv
// Flag/stack bus between execute-stage control and the NZCV flag stack.
// The master drives updates, stack operations and cond; the slave returns flag state and status.
interface nzcv_flag_stack_if #(
  parameter int FLAG_W = 4,
  parameter int LVL_W  = 3
);
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] flag_we;
  logic              update_sreg;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [3:0]        cond;
  logic [FLAG_W-1:0] flags_out;
  logic              cond_true;
  logic              stack_full;
  logic              stack_empty;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_err;

  modport master (
    output flags_in, flag_we, update_sreg, push, pop, clr_err, cond,
    input  flags_out, cond_true, stack_full, stack_empty, stack_level, stack_err
  );

  modport slave (
    input  flags_in, flag_we, update_sreg, push, pop, clr_err, cond,
    output flags_out, cond_true, stack_full, stack_empty, stack_level, stack_err
  );
endinterface

// File: rtl/nzcv_flag_stack.sv
// NZCV flag register with per-bit write mask, save/restore stack and B.cond evaluation.
// Define FLAGS_BYPASS_EN to evaluate cond_true on the next-state NZCV (zero-cycle forwarding).
module nzcv_flag_stack #(
  parameter int FLAG_W      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  nzcv_flag_stack_if.slave bus
);
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];
  logic [LVL_W-1:0]  level_q, level_d;
  logic              err_q, err_d;
  logic              full, empty, push_ok, pop_ok, err_new;
  logic [3:0]        nzcv;

  assign full  = (level_q == LVL_W'(STACK_DEPTH));
  assign empty = (level_q == '0);

  always_comb begin
    push_ok = bus.push && !bus.pop && !full;
    pop_ok  = bus.pop && !bus.push && !empty;
    err_new = (bus.push && bus.pop) || (bus.push && !bus.pop && full) ||
              (bus.pop && !bus.push && empty);
    flags_d = flags_q;
    if (bus.update_sreg) flags_d = (flags_q & ~bus.flag_we) | (bus.flags_in & bus.flag_we);
    // A valid pop overrides any same-cycle flag update.
    if (pop_ok) flags_d = stack_q[0];
    level_d = level_q;
    if (push_ok) level_d = level_q + LVL_W'(1);
    if (pop_ok)  level_d = level_q - LVL_W'(1);
    err_d = err_q;
    if (bus.clr_err) err_d = 1'b0;
    if (err_new)     err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Shift-register stack: entry 0 is always the top, so no level-based indexing is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_q[0] <= flags_q;
      for (int i = 1; i < STACK_DEPTH; i++) stack_q[i] <= stack_q[i-1];
    end else if (pop_ok) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) stack_q[i] <= stack_q[i+1];
    end
  end

`ifdef FLAGS_BYPASS_EN
  assign nzcv = flags_d[3:0];
`else
  assign nzcv = flags_q[3:0];
`endif

  always_comb begin
    bus.cond_true = 1'b1;
    case (bus.cond)
      4'b0000: bus.cond_true = nzcv[2];
      4'b0001: bus.cond_true = !nzcv[2];
      4'b0010: bus.cond_true = nzcv[1];
      4'b0011: bus.cond_true = !nzcv[1];
      4'b0100: bus.cond_true = nzcv[3];
      4'b0101: bus.cond_true = !nzcv[3];
      4'b0110: bus.cond_true = nzcv[0];
      4'b0111: bus.cond_true = !nzcv[0];
      4'b1000: bus.cond_true = nzcv[1] && !nzcv[2];
      4'b1001: bus.cond_true = !(nzcv[1] && !nzcv[2]);
      4'b1010: bus.cond_true = (nzcv[3] == nzcv[0]);
      4'b1011: bus.cond_true = (nzcv[3] != nzcv[0]);
      4'b1100: bus.cond_true = !nzcv[2] && (nzcv[3] == nzcv[0]);
      4'b1101: bus.cond_true = !(!nzcv[2] && (nzcv[3] == nzcv[0]));
      default: bus.cond_true = 1'b1;
    endcase
  end

  assign bus.flags_out   = flags_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_level = level_q;
  assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_nzcv_flag_stack.sv
// Directed bench for nzcv_flag_stack: a queue-based flag/stack model checked every cycle,
// plus literal expectations from hand-worked sequences.
module tb_nzcv_flag_stack;
  localparam int FW = 4;
  localparam int DEPTH = 4;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nzcv_flag_stack_if #(.FLAG_W(FW), .LVL_W(LW)) bus ();
  nzcv_flag_stack #(.FLAG_W(FW), .STACK_DEPTH(DEPTH), .LVL_W(LW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;

  logic [FW-1:0] m_flags = '0;
  logic [FW-1:0] m_stk[$];
  logic          m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic cond_of(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  // Flags after this cycle's edge, given the current model state and inputs.
  function automatic logic [FW-1:0] next_flags();
    logic [FW-1:0] f;
    f = m_flags;
    if (bus.pop && !bus.push && m_stk.size() > 0) f = m_stk[$];
    else if (bus.update_sreg) f = (m_flags & ~bus.flag_we) | (bus.flags_in & bus.flag_we);
    return f;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_flags = '0;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      logic [FW-1:0] nf;
      logic e;
      nf = next_flags();
      e = 1'b0;
      if (bus.push && bus.pop) e = 1'b1;
      else if (bus.push) begin
        if (m_stk.size() == DEPTH) e = 1'b1;
        else m_stk.push_back(m_flags);
      end else if (bus.pop) begin
        if (m_stk.size() == 0) e = 1'b1;
        else void'(m_stk.pop_back());
      end
      m_flags = nf;
      m_err = e ? 1'b1 : (bus.clr_err ? 1'b0 : m_err);
    end
    chk_en = 1'b1;
  end

  always begin
    @(negedge clk);
    #3;
    if (chk_en) begin
      logic [3:0] ev;
`ifdef FLAGS_BYPASS_EN
      ev = reset ? m_flags[3:0] : next_flags();
`else
      ev = m_flags[3:0];
`endif
      chk("flags_out", 32'(bus.flags_out), 32'(m_flags));
      chk("stack_level", 32'(bus.stack_level), 32'(m_stk.size()));
      chk("stack_full", 32'(bus.stack_full), 32'(m_stk.size() == DEPTH));
      chk("stack_empty", 32'(bus.stack_empty), 32'(m_stk.size() == 0));
      chk("stack_err", 32'(bus.stack_err), 32'(m_err));
      if (!reset) chk("cond_true", 32'(bus.cond_true), 32'(cond_of(bus.cond, ev)));
    end
  end

  task automatic drive(input logic rst, input logic upd, input logic ps, input logic pp,
                       input logic clr, input logic [3:0] fin, input logic [3:0] we,
                       input logic [3:0] cnd);
    @(negedge clk);
    #1;
    reset = rst;
    bus.update_sreg = upd;
    bus.push = ps;
    bus.pop = pp;
    bus.clr_err = clr;
    bus.flags_in = fin;
    bus.flag_we = we;
    bus.cond = cnd;
    #1;
  endtask

  task automatic idle(input logic [3:0] cnd);
    drive(0, 0, 0, 0, 0, 4'h0, 4'h0, cnd);
  endtask

  initial begin
    bus.update_sreg = 0; bus.push = 0; bus.pop = 0; bus.clr_err = 0;
    bus.flags_in = '0; bus.flag_we = '0; bus.cond = '0;
    drive(1, 1, 1, 0, 0, 4'hF, 4'hF, 4'h0);
    drive(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    idle(4'h0);
    chk("rst_flags", 32'(bus.flags_out), 32'h0);
    chk("rst_empty", 32'(bus.stack_empty), 32'h1);
    chk("rst_full", 32'(bus.stack_full), 32'h0);
    chk("rst_err", 32'(bus.stack_err), 32'h0);

    // Plan 1: Z set
    drive(0, 1, 0, 0, 0, 4'h4, 4'hF, 4'h0);
    idle(4'h0);
    chk("p1_flags", 32'(bus.flags_out), 32'h4);
    chk("p1_eq", 32'(bus.cond_true), 32'h1);
    idle(4'h1);
    chk("p1_ne", 32'(bus.cond_true), 32'h0);

    // Plan 2: masked update
    drive(0, 1, 0, 0, 0, 4'hA, 4'hF, 4'h0);
    drive(0, 1, 0, 0, 0, 4'h5, 4'h3, 4'hA);
    idle(4'hA);
    chk("p2_flags", 32'(bus.flags_out), 32'h9);
    chk("p2_ge", 32'(bus.cond_true), 32'h1);
    drive(0, 1, 0, 0, 0, 4'hF, 4'h0, 4'hA);
    idle(4'hA);
    chk("we0_noop", 32'(bus.flags_out), 32'h9);

    // Plan 3: fill, overflow, drain
    drive(0, 1, 0, 0, 0, 4'h1, 4'hF, 4'h0);
    for (int i = 2; i <= 5; i++) drive(0, 1, 1, 0, 0, 4'(i), 4'hF, 4'h8);
    idle(4'h0);
    chk("p3_full", 32'(bus.stack_full), 32'h1);
    chk("p3_level", 32'(bus.stack_level), 32'h4);
    drive(0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0);
    idle(4'h0);
    chk("p3_ovf_err", 32'(bus.stack_err), 32'h1);
    chk("p3_ovf_level", 32'(bus.stack_level), 32'h4);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h3);
      idle(4'h3);
      chk("p3_pop_flags", 32'(bus.flags_out), 32'(4 - k));
    end
    chk("p3_empty", 32'(bus.stack_empty), 32'h1);

    // Plan 4: underflow with update, clear
    drive(0, 1, 0, 1, 0, 4'hF, 4'hF, 4'hC);
    idle(4'hC);
    chk("p4_err", 32'(bus.stack_err), 32'h1);
    chk("p4_flags", 32'(bus.flags_out), 32'hF);
    drive(0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h0);
    idle(4'h0);
    chk("clr_vs_new_err", 32'(bus.stack_err), 32'h1);
    drive(0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    idle(4'h0);
    chk("p4_clr", 32'(bus.stack_err), 32'h0);

    // Plan 5: push+pop error, pop beats update, reset mid-sequence
    drive(0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0);
    drive(0, 1, 1, 0, 0, 4'h6, 4'hF, 4'h0);
    drive(0, 1, 1, 1, 0, 4'h3, 4'hF, 4'h0);
    idle(4'h0);
    chk("p5_level", 32'(bus.stack_level), 32'h2);
    chk("p5_err", 32'(bus.stack_err), 32'h1);
    chk("p5_upd", 32'(bus.flags_out), 32'h3);
    drive(0, 1, 0, 1, 0, 4'h7, 4'hF, 4'h0);
    idle(4'h0);
    chk("pop_wins", 32'(bus.flags_out), 32'hF);
    drive(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    idle(4'h0);
    chk("p5_rst_level", 32'(bus.stack_level), 32'h0);
    chk("p5_rst_flags", 32'(bus.flags_out), 32'h0);
    chk("p5_rst_err", 32'(bus.stack_err), 32'h0);

    // Plan 6: flag-to-branch latency
    drive(0, 1, 0, 0, 0, 4'h4, 4'h4, 4'h0);
`ifdef FLAGS_BYPASS_EN
    chk("p6_same_cycle", 32'(bus.cond_true), 32'h1);
`else
    chk("p6_same_cycle", 32'(bus.cond_true), 32'h0);
`endif
    idle(4'h0);
    chk("p6_next_cycle", 32'(bus.cond_true), 32'h1);

    // Every flag pattern against rotating condition codes (model-checked).
    for (int v = 0; v < 16; v++) begin
      drive(0, 1, 0, 0, 0, 4'(v), 4'hF, 4'(v * 7 + 3));
      idle(4'(v));
      idle(4'(v ^ 1));
    end

    idle(4'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/nzcv_flag_stack.md
Name: nzcv_flag_stack

Overview:
- Parametrised successor to the single NZCV status register in the execute stage.
- Holds FLAG_W flag bits with per-bit write masking.
- Adds a save/restore stack of depth STACK_DEPTH for exception entry/return.
- Evaluates the LEGv8 4-bit condition code for B.cond, so branch logic reads one cond_true bit.

Parameters:
FLAG_W, 4, flag width; bits [3:0] are N,Z,C,V (bit3=N, bit2=Z, bit1=C, bit0=V); bits above 3 are general sticky/user flags; must be >=4
STACK_DEPTH, 4, number of save slots; must be >=1
LVL_W, $clog2(STACK_DEPTH+1), width of stack_level

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
flags_in  input  FLAG_W  new flag values from ALU
flag_we  input  FLAG_W  per-bit write mask, qualified by update_sreg
update_sreg  input  1  write flags_in into flags_out where flag_we=1
push  input  1  save current flags_out onto stack
pop  input  1  restore top of stack into flags_out
clr_err  input  1  clear stack_err
cond  input  4  condition code for evaluation
flags_out  output  FLAG_W  registered flag state
cond_true  output  1  condition evaluation result
stack_full  output  1  level == STACK_DEPTH
stack_empty  output  1  level == 0
stack_level  output  LVL_W  number of occupied slots
stack_err  output  1  sticky misuse indicator

Behaviour:
- One clock domain; reset is synchronous and active-high; clock port is clk, reset port is reset. Polarity and synchronicity are fixed.
- Reset:
  - flags_out=0, stack_level=0, stack_empty=1, stack_full=0, stack_err=0.
  - Stack contents are don't-care.
  - Reset beats every other input in the same cycle.
  - Reset mid-sequence discards all saved entries.
- Update:
  - When update_sreg=1, flags_out[i] <= flags_in[i] for each i with flag_we[i]=1.
  - Other bits hold.
  - update_sreg=1 with flag_we=0 is a legal no-op.
  - Latency: 1 cycle.
- Push (push=1, pop=0, not full):
  - stack[level] <= flags_out value *before* any same-cycle update; level+1.
  - Same-cycle update_sreg still applies to flags_out.
- Pop (pop=1, push=0, not empty):
  - flags_out <= stack[level-1]; level-1.
  - Same-cycle update_sreg is dropped; pop wins.
- Error cases (stack_err set, stack and flags unchanged by the stack operation):
  - Push when full: update_sreg still applies.
  - Pop when empty: update_sreg still applies.
  - push=1 and pop=1 together: update_sreg still applies.
- stack_err:
  - Sticky; cleared only by reset, or by clr_err when no new error occurs that cycle.
  - A new error in the same cycle as clr_err leaves it at 1.
- Status outputs: stack_full, stack_empty and stack_level are registered-state derived, with no combinational path from push/pop.
- cond_true is combinational from flags_out and cond (N,Z,C,V = flags_out[3:0]):
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 HS: C. 0011 LO: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !(C&!Z).
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: !(!Z&(N==V)).
  - 1110 AL: 1. 1111 NV: 1.
- Upper flag bits (>=4) never affect cond_true.

Optional Feature:
- Macro: FLAGS_BYPASS_EN.
- Defined: cond_true is evaluated on the next-state NZCV value.
  - If update_sreg=1 and no pop, each NZCV bit with flag_we=1 is taken from flags_in.
  - If a valid pop occurs, the popped value is used.
  - Gives zero-cycle flag-to-branch forwarding (CMP followed immediately by B.cond).
- Not defined: cond_true uses registered flags_out only, adding 1 cycle of flag-to-branch latency.
- Registered outputs are identical in both builds.

Test Plan:
1. Reset then update_sreg=1, flag_we=4'b1111, flags_in=4'b0100 -> next cycle flags_out=4'b0100; cond=0000 gives cond_true=1, cond=0001 gives 0.
2. flags_out=4'b1010, update_sreg=1, flag_we=4'b0011, flags_in=4'b0101 -> flags_out=4'b1001; cond=1010 (GE) gives cond_true=1.
3. With DEPTH=4, push 4 times with flags 1,2,3,4 (update each cycle) -> stack_full=1, level=4; 5th push -> stack_err=1, level stays 4; 4 pops -> flags_out=4,3,2,1 in order, stack_empty=1.
4. Pop on empty with update_sreg=1, flags_in=4'b1111, flag_we=4'b1111 -> stack_err=1, flags_out=4'b1111; clr_err next cycle -> stack_err=0.
5. level=2, push=1 and pop=1 -> level stays 2, stack_err=1; then reset -> level=0, flags_out=0, stack_err=0.
6. FLAGS_BYPASS_EN defined: flags_out=0, update_sreg=1, flag_we=4'b0100, flags_in=4'b0100, cond=0000 -> cond_true=1 same cycle. Macro undefined: cond_true=0 that cycle and 1 the next.
